// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command sequencer for a bank of reset-less JK flip-flops.
// Takes one command at a time over valid/ready. It drives per-bit j/k for
// as many clock edges as the command needs, and it reads the bank back on
// i_q_in for the synchronous count.
//
// state   | meaning
// --------+-----------------------------------------------------------
// INIT    | one cycle after reset, j=0 k=1 so the bank is held at zero
// IDLE    | j=k=0, ready for a command; done/err pulse shows here
// APPLY   | single bank-update edge for NOP/SET/CLR/TOG/LOAD/illegal
// COUNT   | masked synchronous up-count, one increment per cycle
module jk_bank_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_mask,
    input  logic [WIDTH-1:0] i_cmd_data,
    input  logic [CNT_W-1:0] i_cmd_count,
    output logic [WIDTH-1:0] o_jk_j,
    output logic [WIDTH-1:0] o_jk_k,
    input  logic [WIDTH-1:0] i_q_in,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_APPLY = 2'd2,
        ST_COUNT = 2'd3
    } state_t;

    localparam logic [2:0] OP_SET   = 3'd1;
    localparam logic [2:0] OP_CLR   = 3'd2;
    localparam logic [2:0] OP_TOG   = 3'd3;
    localparam logic [2:0] OP_LOAD  = 3'd4;
    localparam logic [2:0] OP_COUNT = 3'd5;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_rem;
    logic             r_done;
    logic             r_err;

    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_tog;
    logic             w_ready;
    logic             w_busy;
    logic             w_finish;
    logic             w_finish_err;
    logic             w_accept;

    assign w_accept = o_cmd_ready & i_cmd_valid;

    // State register; reset always restarts through INIT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Command capture, repeat counter and completion pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op   <= '0;
            r_mask <= '0;
            r_data <= '0;
            r_rem  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_finish;
            r_err  <= w_finish_err;
            if (w_accept) begin
                r_op   <= i_cmd_op;
                r_mask <= i_cmd_mask;
                r_data <= i_cmd_data;
                // A zero count still gives one count edge.
                r_rem  <= (i_cmd_count == '0) ? CNT_W'(1) : i_cmd_count;
            end else if (r_state == ST_COUNT) begin
                r_rem <= r_rem - CNT_W'(1);
            end
        end
    end

    // Toggle enables of a masked up-counter. Unmasked bits pass the carry
    // through, so the masked bits count as one packed counter.
    always_comb begin
        logic carry;
        w_tog = '0;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_tog[i] = r_mask[i] & carry;
            carry    = carry & (i_q_in[i] | ~r_mask[i]);
        end
    end

    // Next state, per-state j/k drive and status.
    always_comb begin
        w_next       = r_state;
        w_j          = '0;
        w_k          = '0;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_finish     = 1'b0;
        w_finish_err = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_k    = '1;
                w_busy = 1'b1;
                w_next = ST_IDLE;
            end
            ST_IDLE: begin
                w_ready = 1'b1;
                if (i_cmd_valid) begin
                    w_next = (i_cmd_op == OP_COUNT) ? ST_COUNT : ST_APPLY;
                end
            end
            ST_APPLY: begin
                w_busy       = 1'b1;
                w_finish     = 1'b1;
                w_finish_err = (r_op[2:1] == 2'b11);
                w_next       = ST_IDLE;
                case (r_op)
                    OP_SET:  w_j = r_mask;
                    OP_CLR:  w_k = r_mask;
                    OP_TOG: begin
                        w_j = r_mask;
                        w_k = r_mask;
                    end
                    OP_LOAD: begin
                        w_j = r_data & r_mask;
                        w_k = ~r_data & r_mask;
                    end
                    default: begin
                        w_j = '0;
                        w_k = '0;
                    end
                endcase
            end
            ST_COUNT: begin
                w_busy = 1'b1;
                w_j    = w_tog;
                w_k    = w_tog;
                // A remaining count of zero cannot normally occur; it is treated as the last edge.
                if (r_rem <= CNT_W'(1)) begin
                    w_finish = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_INIT;
            end
        endcase
    end

    // Reset forces a clear on the bank every reset edge, because the
    // flip-flops have no reset of their own.
    assign o_jk_j      = i_rst ? '0 : w_j;
    assign o_jk_k      = i_rst ? '1 : w_k;
    assign o_cmd_ready = w_ready & ~i_rst;
    assign o_busy      = w_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule
